// File: rtl/rf_multiport.sv
// rf_multiport: DEPTH x WIDTH register file with one write port, two registered read ports and a
// top entry that captures synchronised io_in. Optional write-first bypass: define RF_BYPASS_EN.
module rf_multiport #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       re_a,
    input  logic [$clog2(DEPTH)-1:0]   raddr_a,
    output logic [WIDTH-1:0]           rdata_a,
    input  logic                       re_b,
    input  logic [$clog2(DEPTH)-1:0]   raddr_b,
    output logic [WIDTH-1:0]           rdata_b,
    input  logic [WIDTH-1:0]           io_in,
    input  logic                       io_ce,
    output logic                       io_chg
);

    localparam int              AW     = $clog2(DEPTH);
    localparam logic [AW-1:0]   IO_IDX = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_r  [DEPTH];
    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] rdata_a_r;
    logic [WIDTH-1:0] rdata_b_r;
    logic             io_chg_r;

    logic             wr_ok_s;
    logic [WIDTH-1:0] sync_out_s;
    logic [WIDTH-1:0] io_cur_s;
    logic [WIDTH-1:0] rd_a_s;
    logic [WIDTH-1:0] rd_b_s;

    // The I/O entry is owned by the capture path, so the write port never touches it.
    assign wr_ok_s    = we && (waddr != IO_IDX);
    assign sync_out_s = sync_r[SYNC_STAGES-1];
    assign io_cur_s   = mem_r[IO_IDX];

    // Port A read-data source: stored entry, or incoming write data in write-first mode.
    always_comb begin
        rd_a_s = mem_r[raddr_a];
`ifdef RF_BYPASS_EN
        if (wr_ok_s && (waddr == raddr_a)) begin
            rd_a_s = wdata;
        end else begin
            rd_a_s = mem_r[raddr_a];
        end
`endif
    end

    // Port B read-data source: stored entry, or incoming write data in write-first mode.
    always_comb begin
        rd_b_s = mem_r[raddr_b];
`ifdef RF_BYPASS_EN
        if (wr_ok_s && (waddr == raddr_b)) begin
            rd_b_s = wdata;
        end else begin
            rd_b_s = mem_r[raddr_b];
        end
`endif
    end

    // io_in synchroniser chain, free-running regardless of io_ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= io_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Entry storage: general write port plus capture into the I/O entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (wr_ok_s) begin
                mem_r[waddr] <= wdata;
            end
            if (io_ce) begin
                mem_r[IO_IDX] <= sync_out_s;
            end
        end
    end

    // Registered read ports; a deasserted enable holds the last data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a_r <= {WIDTH{1'b0}};
            rdata_b_r <= {WIDTH{1'b0}};
        end else begin
            if (re_a) begin
                rdata_a_r <= rd_a_s;
            end
            if (re_b) begin
                rdata_b_r <= rd_b_s;
            end
        end
    end

    // Change flag: one-cycle pulse when a capture alters the I/O entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_chg_r <= 1'b0;
        end else begin
            io_chg_r <= io_ce && (sync_out_s != io_cur_s);
        end
    end

    assign rdata_a = rdata_a_r;
    assign rdata_b = rdata_b_r;
    assign io_chg  = io_chg_r;

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench for rf_multiport: directed checks on the 4x8 default build and a
// randomized 8x16 regression against a behavioural model.
module tb_rf_multiport;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    // default 4x8 instance
    logic        we, re_a, re_b, io_ce;
    logic [1:0]  waddr, raddr_a, raddr_b;
    logic [7:0]  wdata, io_in, rdata_a, rdata_b;
    logic        io_chg;

    // 8x16 instance
    logic        w_we, w_re_a, w_re_b, w_io_ce;
    logic [2:0]  w_waddr, w_raddr_a, w_raddr_b;
    logic [15:0] w_wdata, w_io_in, w_rdata_a, w_rdata_b;
    logic        w_io_chg;

    always #5 clk = ~clk;

    rf_multiport dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .io_in(io_in), .io_ce(io_ce), .io_chg(io_chg)
    );

    rf_multiport #(.WIDTH(16), .DEPTH(8), .SYNC_STAGES(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .we(w_we), .waddr(w_waddr), .wdata(w_wdata),
        .re_a(w_re_a), .raddr_a(w_raddr_a), .rdata_a(w_rdata_a),
        .re_b(w_re_b), .raddr_b(w_raddr_b), .rdata_b(w_rdata_b),
        .io_in(w_io_in), .io_ce(w_io_ce), .io_chg(w_io_chg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; re_a = 1'b0; re_b = 1'b0; io_ce = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_a;
        idle();
        waddr = 2'd0; wdata = 8'h00; raddr_a = 2'd0; raddr_b = 2'd0; io_in = 8'h00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        // load entries then read one so the outputs are non-zero before reset
        for (int i = 0; i < 3; i++) begin
            we = 1'b1; waddr = 2'(i); wdata = 8'(8'h31 + 8'(i)); tick();
        end
        we = 1'b0; re_a = 1'b1; raddr_a = 2'd1; re_b = 1'b1; raddr_b = 2'd2;
        tick();
        exp_a = 8'h32;
        n_cmp++;
        if (rdata_a !== exp_a) begin
            n_err++; $display("FAIL pre_reset_a: got %h expected %h", rdata_a, exp_a);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rdata_a !== 8'h00 || rdata_b !== 8'h00 || io_chg !== 1'b0) begin
            n_err++; $display("FAIL reset_outputs: got a=%h b=%h chg=%b expected 00 00 0", rdata_a, rdata_b, io_chg);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            re_a = 1'b1; raddr_a = 2'(i); re_b = 1'b1; raddr_b = 2'(3 - i);
            tick();
            n_cmp++;
            if (rdata_a !== 8'h00 || rdata_b !== 8'h00) begin
                n_err++; $display("FAIL reset_entry_%0d: got a=%h b=%h expected 00 00", i, rdata_a, rdata_b);
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 2'd1; wdata = 8'h5A; tick();
        waddr = 2'd2; wdata = 8'hC3; tick();
        we = 1'b0; re_a = 1'b1; raddr_a = 2'd1; re_b = 1'b1; raddr_b = 2'd2;
        tick();
        n_cmp++;
        if (rdata_a !== 8'h5A || rdata_b !== 8'hC3) begin
            n_err++; $display("FAIL write_read: got a=%h b=%h expected 5a c3", rdata_a, rdata_b);
        end
        re_a = 1'b0; re_b = 1'b0; raddr_a = 2'd0; raddr_b = 2'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (rdata_a !== 8'h5A || rdata_b !== 8'hC3) begin
                n_err++; $display("FAIL read_hold: got a=%h b=%h expected 5a c3", rdata_a, rdata_b);
            end
        end
        // same address on both ports
        re_a = 1'b1; re_b = 1'b1; raddr_a = 2'd2; raddr_b = 2'd2;
        tick();
        n_cmp++;
        if (rdata_a !== 8'hC3 || rdata_b !== 8'hC3) begin
            n_err++; $display("FAIL same_addr: got a=%h b=%h expected c3 c3", rdata_a, rdata_b);
        end
        idle();
    endtask

    task automatic test_same_cycle();
        logic [7:0] exp_a;
        we = 1'b1; waddr = 2'd1; wdata = 8'h11; tick();
        wdata = 8'h22; re_a = 1'b1; raddr_a = 2'd1;
        tick();
        exp_a = BYP ? 8'h22 : 8'h11;
        n_cmp++;
        if (rdata_a !== exp_a) begin
            n_err++; $display("FAIL same_cycle: got %h expected %h", rdata_a, exp_a);
        end
        we = 1'b0;
        tick();
        n_cmp++;
        if (rdata_a !== 8'h22) begin
            n_err++; $display("FAIL after_write: got %h expected 22", rdata_a);
        end
        idle();
    endtask

    task automatic test_io_capture();
        logic [7:0] exp_b [5];
        logic       exp_c [5];
        exp_b = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5};
        exp_c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        io_in = 8'hA5; io_ce = 1'b1; re_b = 1'b1; raddr_b = 2'd3;
        for (int e = 0; e < 5; e++) begin
            tick();
            n_cmp++;
            if (io_chg !== exp_c[e] || rdata_b !== exp_b[e]) begin
                n_err++; $display("FAIL io_capture_edge%0d: got chg=%b b=%h expected %b %h",
                                  e + 1, io_chg, rdata_b, exp_c[e], exp_b[e]);
            end
        end
        idle();
    endtask

    task automatic test_io_protect();
        we = 1'b1; waddr = 2'd3; wdata = 8'hFF; io_in = 8'h3C; tick();
        we = 1'b0;
        tick(); tick();
        re_a = 1'b1; raddr_a = 2'd3;
        tick();
        n_cmp++;
        if (rdata_a !== 8'hA5 || io_chg !== 1'b0) begin
            n_err++; $display("FAIL io_protect: got a=%h chg=%b expected a5 0", rdata_a, io_chg);
        end
        io_in = 8'hA5;
        idle();
    endtask

    task automatic test_random();
        logic [15:0] m [8];
        logic [15:0] hist [$];
        logic [15:0] ea, eb, sync_o;
        logic        ec;
        for (int i = 0; i < 8; i++) m[i] = 16'h0000;
        hist = {16'h0000, 16'h0000};
        ea = 16'h0000; eb = 16'h0000;
        for (int c = 0; c < 10000; c++) begin
            w_we      = 1'($urandom_range(0, 1));
            w_waddr   = 3'($urandom_range(0, 7));
            w_wdata   = 16'($urandom);
            w_re_a    = 1'($urandom_range(0, 3) != 0);
            w_raddr_a = ($urandom_range(0, 3) == 0) ? w_waddr : 3'($urandom_range(0, 7));
            w_re_b    = 1'($urandom_range(0, 3) != 0);
            w_raddr_b = ($urandom_range(0, 3) == 0) ? w_waddr : 3'($urandom_range(0, 7));
            w_io_ce   = 1'($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) w_io_in = 16'($urandom);
            sync_o = hist[0];
            if (w_re_a) ea = (BYP && w_we && w_waddr == w_raddr_a && w_waddr != 3'd7) ? w_wdata : m[w_raddr_a];
            if (w_re_b) eb = (BYP && w_we && w_waddr == w_raddr_b && w_waddr != 3'd7) ? w_wdata : m[w_raddr_b];
            ec = w_io_ce && (sync_o != m[7]);
            if (w_we && w_waddr != 3'd7) m[w_waddr] = w_wdata;
            if (w_io_ce) m[7] = sync_o;
            void'(hist.pop_front());
            hist.push_back(w_io_in);
            tick();
            n_cmp++;
            if (w_rdata_a !== ea || w_rdata_b !== eb || w_io_chg !== ec) begin
                n_err++;
                if (n_err < 20) $display("FAIL random_c%0d: got a=%h b=%h chg=%b expected %h %h %b",
                                         c, w_rdata_a, w_rdata_b, w_io_chg, ea, eb, ec);
            end
        end
        w_we = 1'b0; w_re_a = 1'b0; w_re_b = 1'b0; w_io_ce = 1'b0;
    endtask

    initial begin
        w_we = 1'b0; w_waddr = 3'd0; w_wdata = 16'h0000; w_re_a = 1'b0; w_raddr_a = 3'd0;
        w_re_b = 1'b0; w_raddr_b = 3'd0; w_io_in = 16'h0000; w_io_ce = 1'b0;
        test_reset();
        test_write_read();
        test_same_cycle();
        test_io_capture();
        test_io_protect();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
